alu_cmd_driver: RTL and testbench
=================================

# alu_cmd_driver

Sequential command initiator that sits in front of the combinational 8-bit ALU. It accepts operation commands over a valid/ready handshake, drives the ALU's opcode and operand ports, and waits a fixed settle time. It then captures the 16-bit ALU result and returns it with status flags over a second valid/ready handshake. It is the clocked control end of the ALU interface, used by any upstream sequencer or testbench that issues ALU operations.

## Interface
- SETTLE_CYCLES, default 1: cycles between driving the ALU ports and capturing its result; legal range 1..15.
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  driver can accept a command.
- cmd_sel  input  4  ALU opcode.
- cmd_a  input  8  operand a.
- cmd_b  input  8  operand b.
- cmd_use_acc  input  1  use the accumulator as operand a (see Configuration).
- alu_sel  output  4  registered opcode to the ALU `sel`.
- alu_a  output  8  registered operand to the ALU `a`.
- alu_b  output  8  registered operand to the ALU `b`.
- alu_fout  input  16  ALU result.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts the result.
- rsp_data  output  16  captured ALU result.
- rsp_zero  output  1  rsp_data == 0.
- rsp_hi  output  1  |rsp_data[15:8], meaning a carry or upper product bits.
- rsp_err  output  1  command opcode was 4'd15, which is unassigned in the ALU.
- op_count  output  16  count of completed responses; wraps from 16'hFFFF to 0.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, register cmd_sel, cmd_a (or the accumulator) and cmd_b into alu_sel/alu_a/alu_b.
  - Latch err=(cmd_sel==4'd15), load the settle counter with SETTLE_CYCLES-1, and go to WAIT.
- WAIT
  - cmd_ready=0.
  - Decrement the counter each cycle.
  - On the cycle the counter is 0, capture alu_fout into rsp_data, compute rsp_zero/rsp_hi, and go to RESP.
- RESP
  - rsp_valid=1, cmd_ready=0.
  - rsp_data and all flags stay stable while rsp_ready=0.
  - On rsp_valid&&rsp_ready: increment op_count, then go to IDLE.
- alu_sel/alu_a/alu_b hold their last value outside command acceptance; they are not cleared after a response.
- Opcode 15 is still driven to the ALU. The ALU returns 0, so the response carries rsp_data=0, rsp_zero=1, rsp_err=1.
- All arithmetic is done by the ALU; the driver never modifies alu_fout.
- Reset (asynchronous, any state, including WAIT or RESP):
  - state=IDLE.
  - alu_sel/alu_a/alu_b=0.
  - rsp_data=0, rsp_valid=0, all flags 0, op_count=0.
  - The accumulator is cleared to 0.
  - An in-flight command is discarded and no response is produced.

## Timing
- Accept at edge N: alu_* valid after edge N; rsp_valid rises after edge N+SETTLE_CYCLES.
- Latency from accept edge to rsp_valid = SETTLE_CYCLES cycles.
- With rsp_ready held high, the response handshake occurs on the first RESP edge. cmd_ready returns high the following cycle.
- Maximum throughput is one command per SETTLE_CYCLES+2 cycles.
- No combinational path from cmd_* or rsp_ready to any output except through state.
- cmd_ready is a pure function of state.

## Configuration
- Macro: ALU_CMD_DRIVER_ACC_EN.
- Defined:
  - An 8-bit accumulator register loads rsp_data[7:0] on every response handshake.
  - At command accept with cmd_use_acc=1, alu_a takes the accumulator value instead of cmd_a.
- Undefined:
  - No accumulator register exists.
  - cmd_use_acc is ignored; alu_a always takes cmd_a.
  - The port is retained in both builds.

## Test plan
- Reset: hold rst_n=0 with random inputs, release.
  - Expect cmd_ready=1, rsp_valid=0, alu_*=0, op_count=0.
- Add, SETTLE_CYCLES=1: cmd_sel=1, a=200, b=100.
  - Expect rsp_valid one cycle after accept, rsp_data=16'h012C, rsp_hi=1, rsp_zero=0, op_count=1.
- Multiply with backpressure: cmd_sel=0, a=15, b=17, rsp_ready low 3 cycles.
  - Expect rsp_data=16'h00FF held stable, cmd_ready=0 throughout, rsp_hi=0.
- Opcode 15: cmd_sel=15, a=8'hAA, b=8'h55.
  - Expect rsp_data=0, rsp_zero=1, rsp_err=1.
- Accumulator (ALU_CMD_DRIVER_ACC_EN defined):
  - AND 8'hF0 with 8'h3C gives 16'h0030.
  - Then add with cmd_use_acc=1, cmd_a=8'hFF, b=8'h10: expect alu_a=8'h30, rsp_data=16'h0040.
  - Without the macro the same add returns 16'h010F.
- Reset mid-operation: SETTLE_CYCLES=4, assert rst_n=0 during WAIT.
  - Expect no rsp_valid, op_count=0, and a subsequent command completing normally.

Source files
------------

// File: rtl/alu_cmd_driver.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmd_driver
// Purpose  : Clocked command initiator for the combinational 8-bit ALU.
//            Accepts a command over a valid/ready handshake, drives the ALU
//            opcode/operand ports from registers, waits SETTLE_CYCLES, then
//            captures the 16-bit ALU result and returns it with status flags
//            over a second valid/ready handshake.
// Ports    : clk, rst_n (async, active-low)
//            cmd_valid/cmd_ready, cmd_sel[3:0], cmd_a[7:0], cmd_b[7:0],
//            cmd_use_acc                       -- command side
//            alu_sel[3:0], alu_a[7:0], alu_b[7:0], alu_fout[15:0] -- ALU side
//            rsp_valid/rsp_ready, rsp_data[15:0], rsp_zero, rsp_hi, rsp_err
//                                              -- response side
//            op_count[15:0]                    -- completed responses
// Options  : `define ALU_CMD_DRIVER_ACC_EN to build the 8-bit accumulator that
//            can replace cmd_a when cmd_use_acc=1. Without it cmd_use_acc is
//            ignored.
// Revision : 1.0 - initial release
// ============================================================================
module alu_cmd_driver #(
  parameter int SETTLE_CYCLES = 1   // legal range 1..15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_sel,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic        cmd_use_acc,
  output logic [3:0]  alu_sel,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  input  logic [15:0] alu_fout,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_zero,
  output logic        rsp_hi,
  output logic        rsp_err,
  output logic [15:0] op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0] OPC_UNASSIGNED = 4'd15;

  state_t      state;
  logic [3:0]  settle_cnt;
  logic        err_pend;     // opcode-15 flag held until the result is captured
  logic [7:0]  a_src;        // operand a selected at command accept

`ifdef ALU_CMD_DRIVER_ACC_EN
  logic [7:0] acc;

  assign a_src = cmd_use_acc ? acc : cmd_a;

  // Accumulator follows the low byte of every delivered result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= 8'd0;
    end else if (state == RESP && rsp_ready) begin
      acc <= rsp_data[7:0];
    end
  end
`else
  logic unused_use_acc;

  assign a_src          = cmd_a;
  assign unused_use_acc = cmd_use_acc;
`endif

  // Ready depends only on state, so there is no input-to-output path.
  assign cmd_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      settle_cnt <= 4'd0;
      err_pend   <= 1'b0;
      alu_sel    <= 4'd0;
      alu_a      <= 8'd0;
      alu_b      <= 8'd0;
      rsp_valid  <= 1'b0;
      rsp_data   <= 16'd0;
      rsp_zero   <= 1'b0;
      rsp_hi     <= 1'b0;
      rsp_err    <= 1'b0;
      op_count   <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            alu_sel    <= cmd_sel;
            alu_a      <= a_src;
            alu_b      <= cmd_b;
            err_pend   <= (cmd_sel == OPC_UNASSIGNED);
            settle_cnt <= SETTLE_LOAD;
            state      <= WAIT;
          end
        end

        WAIT: begin
          if (settle_cnt == 4'd0) begin
            // ALU ports have been stable for SETTLE_CYCLES edges.
            rsp_data  <= alu_fout;
            rsp_zero  <= (alu_fout == 16'd0);
            rsp_hi    <= |alu_fout[15:8];
            rsp_err   <= err_pend;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            op_count  <= op_count + 16'd1;
            state     <= IDLE;
          end
        end

        default: begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_cmd_driver
// Purpose  : Directed self-checking bench for alu_cmd_driver. Two instances:
//            dut (SETTLE_CYCLES=1) and dut4 (SETTLE_CYCLES=4), each in front of
//            a behavioural ALU. Honours ALU_CMD_DRIVER_ACC_EN for expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural ALU ----------------
  function automatic logic [15:0] alu_model(input logic [3:0] s,
                                            input logic [7:0] a,
                                            input logic [7:0] b);
    case (s)
      4'd0:    return {8'd0, a} * {8'd0, b};
      4'd1:    return {8'd0, a} + {8'd0, b};
      4'd2:    return {8'd0, a} - {8'd0, b};
      4'd3:    return {8'd0, a & b};
      default: return 16'd0;
    endcase
  endfunction

  // ---------------- dut (SETTLE_CYCLES = 1) ----------------
  logic        rst_n, cmd_valid, cmd_ready, cmd_use_acc, rsp_valid, rsp_ready;
  logic        rsp_zero, rsp_hi, rsp_err;
  logic [3:0]  cmd_sel, alu_sel;
  logic [7:0]  cmd_a, cmd_b, alu_a, alu_b;
  logic [15:0] alu_fout, rsp_data, op_count;

  assign alu_fout = alu_model(alu_sel, alu_a, alu_b);

  alu_cmd_driver #(.SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
    .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_fout(alu_fout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_zero(rsp_zero), .rsp_hi(rsp_hi), .rsp_err(rsp_err),
    .op_count(op_count)
  );

  // ---------------- dut4 (SETTLE_CYCLES = 4) ----------------
  logic        s4_rst_n, s4_cmd_valid, s4_cmd_ready, s4_cmd_use_acc;
  logic        s4_rsp_valid, s4_rsp_ready, s4_rsp_zero, s4_rsp_hi, s4_rsp_err;
  logic [3:0]  s4_cmd_sel, s4_alu_sel;
  logic [7:0]  s4_cmd_a, s4_cmd_b, s4_alu_a, s4_alu_b;
  logic [15:0] s4_alu_fout, s4_rsp_data, s4_op_count;

  assign s4_alu_fout = alu_model(s4_alu_sel, s4_alu_a, s4_alu_b);

  alu_cmd_driver #(.SETTLE_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(s4_rst_n),
    .cmd_valid(s4_cmd_valid), .cmd_ready(s4_cmd_ready), .cmd_sel(s4_cmd_sel),
    .cmd_a(s4_cmd_a), .cmd_b(s4_cmd_b), .cmd_use_acc(s4_cmd_use_acc),
    .alu_sel(s4_alu_sel), .alu_a(s4_alu_a), .alu_b(s4_alu_b),
    .alu_fout(s4_alu_fout),
    .rsp_valid(s4_rsp_valid), .rsp_ready(s4_rsp_ready),
    .rsp_data(s4_rsp_data), .rsp_zero(s4_rsp_zero), .rsp_hi(s4_rsp_hi),
    .rsp_err(s4_rsp_err), .op_count(s4_op_count)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one command on the selected instance; returns cycles from the
  // accept edge until rsp_valid is seen (99 if it never appears).
  task automatic issue(input bit d4, input logic [3:0] s, input logic [7:0] a,
                       input logic [7:0] b, input logic use_acc,
                       output int lat);
    @(negedge clk);
    if (d4) begin
      s4_cmd_valid = 1'b1; s4_cmd_sel = s; s4_cmd_a = a; s4_cmd_b = b;
      s4_cmd_use_acc = use_acc;
    end else begin
      cmd_valid = 1'b1; cmd_sel = s; cmd_a = a; cmd_b = b;
      cmd_use_acc = use_acc;
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid    = 1'b0;
    s4_cmd_valid = 1'b0;
    lat = 0;
    while (!(d4 ? s4_rsp_valid : rsp_valid) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!(d4 ? s4_rsp_valid : rsp_valid)) lat = 99;
  endtask

  int lat;

  initial begin
    // Random inputs while reset is held.
    rst_n = 1'b0; s4_rst_n = 1'b0;
    cmd_valid = 1'($urandom); cmd_sel = 4'($urandom); cmd_a = 8'($urandom);
    cmd_b = 8'($urandom); cmd_use_acc = 1'($urandom); rsp_ready = 1'($urandom);
    s4_cmd_valid = 1'($urandom); s4_cmd_sel = 4'($urandom);
    s4_cmd_a = 8'($urandom); s4_cmd_b = 8'($urandom);
    s4_cmd_use_acc = 1'($urandom); s4_rsp_ready = 1'($urandom);
    repeat (3) @(negedge clk);
    cmd_valid = 1'b0; s4_cmd_valid = 1'b0;
    rsp_ready = 1'b1; s4_rsp_ready = 1'b1;
    cmd_use_acc = 1'b0; s4_cmd_use_acc = 1'b0;
    rst_n = 1'b1; s4_rst_n = 1'b1;
    @(negedge clk);

    // ---- reset state ----
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_alu_ports", {alu_sel, alu_a, alu_b}, 0);
    check("rst_op_count",  op_count, 0);
    check("rst_rsp_data",  rsp_data, 0);

    // ---- add 200 + 100, rsp_ready high ----
    issue(0, 4'd1, 8'd200, 8'd100, 1'b0, lat);
    check("add_latency", lat, 1);
    check("add_data",    rsp_data, 16'h012C);
    check("add_hi",      rsp_hi, 1);
    check("add_zero",    rsp_zero, 0);
    check("add_err",     rsp_err, 0);
    check("add_ready_lo", cmd_ready, 0);
    @(negedge clk);
    check("add_op_count", op_count, 1);
    check("add_rsp_drop", rsp_valid, 0);
    check("add_ready_hi", cmd_ready, 1);

    // ---- multiply 15 * 17 with backpressure ----
    rsp_ready = 1'b0;
    issue(0, 4'd0, 8'd15, 8'd17, 1'b0, lat);
    check("mul_latency", lat, 1);
    for (int i = 0; i < 3; i++) begin
      check("mul_hold_data",  rsp_data, 16'h00FF);
      check("mul_hold_valid", rsp_valid, 1);
      check("mul_hold_ready", cmd_ready, 0);
      check("mul_hold_hi",    rsp_hi, 0);
      @(negedge clk);
    end
    check("mul_opcnt_stall", op_count, 1);
    rsp_ready = 1'b1;
    @(negedge clk);
    check("mul_op_count", op_count, 2);
    check("mul_rsp_drop", rsp_valid, 0);

    // ---- unassigned opcode 15 ----
    issue(0, 4'd15, 8'hAA, 8'h55, 1'b0, lat);
    check("op15_alu_sel", alu_sel, 4'd15);
    check("op15_data",    rsp_data, 16'h0000);
    check("op15_zero",    rsp_zero, 1);
    check("op15_err",     rsp_err, 1);
    @(negedge clk);
    check("op15_op_count", op_count, 3);

    // ---- AND then accumulator-sourced add ----
    issue(0, 4'd3, 8'hF0, 8'h3C, 1'b0, lat);
    check("and_data", rsp_data, 16'h0030);
    check("and_err",  rsp_err, 0);
    @(negedge clk);
    issue(0, 4'd1, 8'hFF, 8'h10, 1'b1, lat);
`ifdef ALU_CMD_DRIVER_ACC_EN
    check("acc_alu_a", alu_a, 8'h30);
    check("acc_data",  rsp_data, 16'h0040);
    check("acc_hi",    rsp_hi, 0);
`else
    check("acc_alu_a", alu_a, 8'hFF);
    check("acc_data",  rsp_data, 16'h010F);
    check("acc_hi",    rsp_hi, 1);
`endif
    @(negedge clk);
    check("acc_op_count", op_count, 5);
    // ALU ports keep the last command after the response.
    check("hold_alu_ports", {alu_sel, alu_a, alu_b},
`ifdef ALU_CMD_DRIVER_ACC_EN
          {4'd1, 8'h30, 8'h10});
`else
          {4'd1, 8'hFF, 8'h10});
`endif

    // ---- dut4: normal command, 4-cycle settle ----
    issue(1, 4'd1, 8'd1, 8'd2, 1'b0, lat);
    check("s4_latency", lat, 4);
    check("s4_data",    s4_rsp_data, 16'h0003);
    @(negedge clk);
    check("s4_op_count", s4_op_count, 1);

    // ---- dut4: reset during WAIT ----
    @(negedge clk);
    s4_cmd_valid = 1'b1; s4_cmd_sel = 4'd0; s4_cmd_a = 8'd9; s4_cmd_b = 8'd9;
    @(posedge clk);
    @(negedge clk);
    s4_cmd_valid = 1'b0;
    check("s4_in_wait", {s4_cmd_ready, s4_rsp_valid}, 2'b00);
    @(negedge clk);
    #2 s4_rst_n = 1'b0;
    #1;
    check("s4_rst_valid",   s4_rsp_valid, 0);
    check("s4_rst_opcnt",   s4_op_count, 0);
    check("s4_rst_alu",     {s4_alu_sel, s4_alu_a, s4_alu_b}, 0);
    @(negedge clk);
    s4_rst_n = 1'b1;
    begin
      int seen = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (s4_rsp_valid) seen++;
      end
      check("s4_no_stale_rsp", seen, 0);
    end
    check("s4_post_rst_ready", s4_cmd_ready, 1);
    issue(1, 4'd1, 8'd5, 8'd6, 1'b0, lat);
    check("s4_post_latency", lat, 4);
    check("s4_post_data",    s4_rsp_data, 16'h000B);
    @(negedge clk);
    check("s4_post_opcnt",   s4_op_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  // Hard stop if the flow above ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
